// File: rtl/panda_pkg.sv
// Shared constants for PandA bit-bus blocks.
package panda_pkg;

   localparam logic EDGE_RISING  = 1'b0;
   localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/panda_srgate_if.sv
// Bit-bus inputs, register fields and gate output of the set/reset gate.
interface panda_srgate_if;

   logic set_i;
   logic rst_i;
   logic SET_EDGE;
   logic RST_EDGE;
   logic FORCE_SET;
   logic FORCE_RST;
   logic out_o;

   modport master (
      output set_i, rst_i, SET_EDGE, RST_EDGE, FORCE_SET, FORCE_RST,
      input  out_o
   );

   modport slave (
      input  set_i, rst_i, SET_EDGE, RST_EDGE, FORCE_SET, FORCE_RST,
      output out_o
   );

endinterface

// File: rtl/panda_edge_sel.sv
// One-cycle delay register plus rising/falling edge select for a bit-bus input.
module panda_edge_sel
   import panda_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   input  logic edge_sel_i,
   output logic evt_o
);

   logic d_prev_q;
   logic rise;
   logic fall;

   // Reset loads the live input so no edge appears on the first cycle out of reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         d_prev_q <= d_i;
      end else begin
         d_prev_q <= d_i;
      end
   end

   assign rise  = d_i & ~d_prev_q;
   assign fall  = ~d_i & d_prev_q;
   assign evt_o = (edge_sel_i == EDGE_FALLING) ? fall : rise;

endmodule

// File: rtl/panda_srgate.sv
// Set/reset gate: registered output set/cleared by selected edges, with force overrides.
module panda_srgate (
   input  logic          clk_i,
   input  logic          reset_i,
   panda_srgate_if.slave bus
);

   logic set_evt;
   logic rst_evt;
   logic out_d;
   logic out_q;

   panda_edge_sel u_set_edge (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .d_i        (bus.set_i),
      .edge_sel_i (bus.SET_EDGE),
      .evt_o      (set_evt)
   );

   panda_edge_sel u_rst_edge (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .d_i        (bus.rst_i),
      .edge_sel_i (bus.RST_EDGE),
      .evt_o      (rst_evt)
   );

   // Clear always outranks set, both for forces and for edge events.
   always_comb begin
      out_d = out_q;
      if (bus.FORCE_RST) begin
         out_d = 1'b0;
      end else if (bus.FORCE_SET) begin
         out_d = 1'b1;
      end else if (rst_evt) begin
         out_d = 1'b0;
      end else if (set_evt) begin
         out_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         out_q <= 1'b0;
      end else begin
         out_q <= out_d;
      end
   end

   assign bus.out_o = out_q;

endmodule

// File: tb/tb_panda_srgate.sv
// Directed bench for panda_srgate: reset, edge modes, collisions, forces, mid-run reset.
`timescale 1ns/1ps
module tb_panda_srgate;

   logic clk_i;
   logic reset_i;
   int   vectors;
   int   miscompares;

   panda_srgate_if bus ();

   panda_srgate dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i       = 1'b1;
      bus.set_i     = 1'b1;
      bus.rst_i     = 1'b0;
      bus.SET_EDGE  = 1'b0;
      bus.RST_EDGE  = 1'b0;
      bus.FORCE_SET = 1'b0;
      bus.FORCE_RST = 1'b0;
      tick();
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      reset_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_1: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_2: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
   endtask

   task automatic test_rising();
      bus.SET_EDGE = 1'b0;
      bus.RST_EDGE = 1'b0;
      bus.set_i    = 1'b0;
      bus.rst_i    = 1'b0;
      tick();
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rise_set: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.set_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL rise_set_fall_ignored: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.rst_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rise_rst: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.rst_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL rise_rst_fall_noop: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
   endtask

   task automatic test_falling();
      bus.SET_EDGE = 1'b1;
      bus.RST_EDGE = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fall_mode_switch: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fall_set_rise_ignored: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL fall_set: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.rst_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL fall_rst_rise_ignored: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.rst_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fall_rst: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
   endtask

   task automatic test_collision();
      bus.SET_EDGE = 1'b0;
      bus.RST_EDGE = 1'b0;
      bus.set_i    = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL coll_preset: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.set_i = 1'b0;
      tick();
      bus.set_i = 1'b1;
      bus.rst_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL coll_from_one: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b0;
      bus.rst_i = 1'b0;
      tick();
      bus.set_i = 1'b1;
      bus.rst_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL coll_from_zero: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b0;
      bus.rst_i = 1'b0;
      tick();
   endtask

   task automatic test_force();
      bus.FORCE_SET = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL force_set: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.FORCE_SET = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL force_set_hold: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.FORCE_RST = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL force_rst: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL force_rst_over_set: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.FORCE_RST = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL force_edge_forgotten: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b0;
      tick();
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL force_preset: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.FORCE_SET = 1'b1;
      bus.FORCE_RST = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL force_both: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.FORCE_SET = 1'b0;
      bus.FORCE_RST = 1'b0;
      tick();
   endtask

   task automatic test_midrun_reset();
      bus.set_i = 1'b0;
      tick();
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_preset: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      reset_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      reset_i = 1'b0;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_release: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.set_i = 1'b0;
      tick();
      bus.set_i = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_reset_reset_again: out_o=%b expected=%b", bus.out_o, 1'b1);
      end
      bus.FORCE_SET = 1'b1;
      reset_i       = 1'b1;
      tick();
      vectors++;
      if (bus.out_o !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_over_force: out_o=%b expected=%b", bus.out_o, 1'b0);
      end
      bus.FORCE_SET = 1'b0;
      reset_i       = 1'b0;
      tick();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_rising();
      test_falling();
      test_collision();
      test_force();
      test_midrun_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
